// File: rtl/cmd_frame_responder_pkg.sv
// Shared definitions for the GSE command frame responder.
// Frame geometry, command/address codes, state encoding, frame packing.
package cmd_frame_responder_pkg;

   localparam int FRAME_LEN = 17;
   localparam int FRAME_W   = FRAME_LEN * 8;
   localparam int CNT_W     = 5;

   // Payload byte offsets within a frame (byte0 goes out first)
   localparam int OFS_CMD   = 0;
   localparam int OFS_ADDR  = 1;
   localparam int OFS_VAL   = 2;
   localparam int VAL_BYTES = 4;
   localparam int HDR_BYTES = OFS_VAL + VAL_BYTES;
   localparam int HDR_W     = HDR_BYTES * 8;

   localparam logic [7:0] C_GET = 8'h01;
   localparam logic [7:0] C_SET = 8'h02;
   localparam logic [7:0] C_ERR = 8'hEE;

   localparam logic [7:0] A_VNUM = 8'h00;
   localparam logic [7:0] A_CFG0 = 8'h01;
   localparam logic [7:0] A_CFG1 = 8'h02;
   localparam logic [7:0] A_CFG2 = 8'h03;

   typedef logic [FRAME_W-1:0] frame_t;

   typedef enum logic [1:0] {
      S_RX,
      S_EXEC,
      S_TX,
      S_TX_REL
   } state_t;

   // {cmd, addr, value, zero fill}, byte0 in the MSBs
   function automatic frame_t pack_frame(
      input logic [7:0]  cmd,
      input logic [7:0]  addr,
      input logic [31:0] val
   );
      return {cmd, addr, val, {(FRAME_W - HDR_W){1'b0}}};
   endfunction

endpackage

// File: rtl/cmd_frame_responder_tx.sv
// hs4_byte_tx: sends a 17-byte frame MSB first over a 4-phase req/ack.
// Ports: load/frame start a send; rsp_data/rsp_req/rsp_ack; done pulses at end.
module hs4_byte_tx
   import cmd_frame_responder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  frame_t     frame,
   output logic [7:0] rsp_data,
   output logic       rsp_req,
   input  logic       rsp_ack,
   output logic       done
);

   // S_RX here means idle: nothing to send
   state_t           st_q, st_d;
   frame_t           sh_q, sh_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [7:0]       data_d;
   logic             req_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q     <= S_RX;
         sh_q     <= '0;
         idx_q    <= '0;
         rsp_data <= '0;
         rsp_req  <= 1'b0;
      end else begin
         st_q     <= st_d;
         sh_q     <= sh_d;
         idx_q    <= idx_d;
         rsp_data <= data_d;
         rsp_req  <= req_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      sh_d   = sh_q;
      idx_d  = idx_q;
      data_d = rsp_data;
      req_d  = rsp_req;
      done   = 1'b0;
      unique case (st_q)
         S_RX: begin
            if (load) begin
               data_d = frame[FRAME_W-1 -: 8];
               sh_d   = frame << 8;
               idx_d  = '0;
               req_d  = 1'b1;
               st_d   = S_TX;
            end
         end
         S_TX: begin
            if (rsp_ack) begin
               req_d = 1'b0;
               st_d  = S_TX_REL;
            end
         end
         S_TX_REL: begin
            if (!rsp_ack) begin
               if (idx_q == CNT_W'(FRAME_LEN - 1)) begin
                  done = 1'b1;
                  st_d = S_RX;
               end else begin
                  data_d = sh_q[FRAME_W-1 -: 8];
                  sh_d   = sh_q << 8;
                  idx_d  = idx_q + 1'b1;
                  req_d  = 1'b1;
                  st_d   = S_TX;
               end
            end
         end
         default: st_d = S_RX;
      endcase
   end

endmodule

// File: rtl/cmd_frame_responder.sv
// GSE command responder: 17-byte frames in, GET/SET on VNUM + CFG0..2, 17 bytes out.
// Ports: clk, rst_n (sync, active-low), cmd_* 4-phase in, rsp_* 4-phase out,
// cfg_0..2 config regs, frame_err pulse. Option: CMD_TIMEOUT_EN (inter-byte timeout).
module cmd_frame_responder
   import cmd_frame_responder_pkg::*;
#(
   parameter logic [31:0] P_VNUM         = 32'h0000_0001,
   parameter int unsigned P_TIMEOUT_CLKS = 500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_req,
   output logic        cmd_ack,
   output logic [7:0]  rsp_data,
   output logic        rsp_req,
   input  logic        rsp_ack,
   output logic [31:0] cfg_0,
   output logic [31:0] cfg_1,
   output logic [31:0] cfg_2,
   output logic        frame_err
);

   // S_TX spans the whole response; its TX/TX_REL phase lives in hs4_byte_tx
   state_t           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [HDR_W-1:0] hdr_q, hdr_d;
   logic             ack_d;
   logic [31:0]      cfg0_d, cfg1_d, cfg2_d;
   logic             capture;
   logic             timeout_hit;
   logic             load;
   logic             tx_done;
   frame_t           rsp_frame;

   logic [7:0]  f_cmd, f_addr;
   logic [31:0] f_val, rd_val;
   logic        hit_vnum, hit_cfg0, hit_cfg1, hit_cfg2;
   logic        get_ok, set_ok;

   assign f_cmd  = hdr_q[HDR_W-1 -: 8];
   assign f_addr = hdr_q[HDR_W-9 -: 8];
   assign f_val  = hdr_q[31:0];

   assign hit_vnum = f_addr == A_VNUM;
   assign hit_cfg0 = f_addr == A_CFG0;
   assign hit_cfg1 = f_addr == A_CFG1;
   assign hit_cfg2 = f_addr == A_CFG2;

   assign set_ok = (f_cmd == C_SET) &&
                   (hit_cfg0 || hit_cfg1 || hit_cfg2);
   assign get_ok = (f_cmd == C_GET) &&
                   (hit_vnum || hit_cfg0 || hit_cfg1 || hit_cfg2);

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         hit_vnum: rd_val = P_VNUM;
         hit_cfg0: rd_val = cfg_0;
         hit_cfg1: rd_val = cfg_1;
         hit_cfg2: rd_val = cfg_2;
         default:  rd_val = '0;
      endcase
   end

   // SET echoes the value just written; rejects carry no value
   assign rsp_frame = (get_ok || set_ok)
      ? pack_frame(f_cmd, f_addr, set_ok ? f_val : rd_val)
      : pack_frame(C_ERR, f_addr, 32'd0);

   assign capture = (st_q == S_RX) && cmd_req && !cmd_ack;

`ifdef CMD_TIMEOUT_EN
   logic [31:0] idle_q;
   logic        idle_run;

   assign idle_run = (st_q == S_RX) && (cnt_q != '0) &&
                     !cmd_req && !cmd_ack;
   assign timeout_hit = idle_run && (idle_q == P_TIMEOUT_CLKS);

   always_ff @(posedge clk) begin
      if (!rst_n || !idle_run || timeout_hit)
         idle_q <= '0;
      else
         idle_q <= idle_q + 32'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^P_TIMEOUT_CLKS;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q    <= S_RX;
         cnt_q   <= '0;
         hdr_q   <= '0;
         cmd_ack <= 1'b0;
         cfg_0   <= '0;
         cfg_1   <= '0;
         cfg_2   <= '0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         cmd_ack <= ack_d;
         cfg_0   <= cfg0_d;
         cfg_1   <= cfg1_d;
         cfg_2   <= cfg2_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      ack_d     = cmd_ack;
      cfg0_d    = cfg_0;
      cfg1_d    = cfg_1;
      cfg2_d    = cfg_2;
      frame_err = 1'b0;
      load      = 1'b0;
      // ack release is independent of state: the last byte's
      // ack is still up when the FSM has already left RX
      if (cmd_ack && !cmd_req)
         ack_d = 1'b0;
      unique case (st_q)
         S_RX: begin
            if (capture) begin
               ack_d = 1'b1;
               if (cnt_q < CNT_W'(HDR_BYTES))
                  hdr_d = {hdr_q[HDR_W-9:0], cmd_data};
               if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                  cnt_d = '0;
                  st_d  = S_EXEC;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (timeout_hit) begin
               cnt_d     = '0;
               frame_err = 1'b1;
            end
         end
         S_EXEC: begin
            load      = 1'b1;
            frame_err = !(get_ok || set_ok);
            st_d      = S_TX;
            if (set_ok) begin
               unique case (1'b1)
                  hit_cfg0: cfg0_d = f_val;
                  hit_cfg1: cfg1_d = f_val;
                  hit_cfg2: cfg2_d = f_val;
                  default:  cfg0_d = cfg_0;
               endcase
            end
         end
         S_TX: begin
            if (tx_done)
               st_d = S_RX;
         end
         default: st_d = S_RX;
      endcase
   end

   hs4_byte_tx u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .frame    (rsp_frame),
      .rsp_data (rsp_data),
      .rsp_req  (rsp_req),
      .rsp_ack  (rsp_ack),
      .done     (tx_done)
   );

endmodule
